// File: rtl/multi_port_register_file.sv
// Multi-port register file: one write port with byte-lane enables and two
// independent registered read ports. The storage array has no reset; a
// sequenced clear engine zeroes it one entry per cycle. The engine runs after
// reset and on request.
module multi_port_register_file #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int RD_BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_req,
  output logic                clear_busy,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                re_a,
  input  logic [ADDR_W-1:0]   raddr_a,
  output logic [DATA_W-1:0]   rdata_a,
  output logic                rvalid_a,
  input  logic                re_b,
  input  logic [ADDR_W-1:0]   raddr_b,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                rvalid_b
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_wr_en;
  logic [DATA_W-1:0]   w_wr_merged;
  logic                w_hit_a;
  logic                w_hit_b;
  logic [DATA_W-1:0]   w_rd_word_a;
  logic [DATA_W-1:0]   w_rd_word_b;

  // Writes are accepted only while the clear engine is parked.
  assign w_wr_en = we && (r_state == ST_IDLE);

  // Merge the enabled write bytes over the currently stored word.
  // NOTE: the output gets a full default before the loop, so no latch can be
  // inferred for lanes whose enable is low.
  always_comb begin
    w_wr_merged = r_mem[waddr];
    for (int i = 0; i < NBYTES; i++) begin
      if (wbe[i]) begin
        w_wr_merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // A read that collides with a same-cycle write sees the merged word when
  // bypass is built in. Otherwise it sees the pre-write contents.
  assign w_hit_a     = (RD_BYPASS != 0) && w_wr_en && (waddr == raddr_a);
  assign w_hit_b     = (RD_BYPASS != 0) && w_wr_en && (waddr == raddr_b);
  assign w_rd_word_a = w_hit_a ? w_wr_merged : r_mem[raddr_a];
  assign w_rd_word_b = w_hit_b ? w_wr_merged : r_mem[raddr_b];

  // Clear-engine FSM. The engine walks every entry exactly once. The walk
  // starts after reset and restarts from entry 0 if reset hits mid-walk.
  // NOTE: sequential state uses non-blocking assignments, so every always_ff
  // block sees the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      clear_busy <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear_req) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= '0;
            clear_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state    <= ST_IDLE;
            clear_busy <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_CLEAR;
          r_clr_ptr  <= '0;
          clear_busy <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: zeroed by the clear engine, otherwise written through the
  // byte-merged write port.
  // NOTE: the array deliberately has no reset branch. It maps onto plain
  // RAM/flop storage, and the clear engine provides its initial contents.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_en) begin
      r_mem[waddr] <= w_wr_merged;
    end
  end

  // Registered read ports. Reads during a clear return zero. An idle port
  // holds its last data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_a  <= '0;
      rvalid_a <= 1'b0;
      rdata_b  <= '0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= re_a;
      rvalid_b <= re_b;
      if (re_a) begin
        rdata_a <= (r_state == ST_CLEAR) ? '0 : w_rd_word_a;
      end
      if (re_b) begin
        rdata_b <= (r_state == ST_CLEAR) ? '0 : w_rd_word_b;
      end
    end
  end

endmodule
